// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: state encoding and default width shared by the PA1 arithmetic blocks
package seq_multiplier_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/seq_multiplier_adder.sv
// mult_adder: combinational unsigned adder exposing the carry-out
module mult_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one multiplier bit per cycle, Run/Rdy handshake
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Mcnd,
  input  logic [WIDTH-1:0]   Mplr,
  output logic [2*WIDTH-1:0] Prod,
  output logic               Rdy
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcnd_q, addend, sum;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0] cnt;
  logic carry, rdy_q, start, step, last;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == BUSY) ? (last ? DONE : BUSY) : (Run ? BUSY : state);
  end
  always_comb begin
    start = state != BUSY && Run;
    step  = state == BUSY;
  end
  // A clear multiplier bit adds zero, so the shift still happens with carry 0
  assign addend = prod_q[0] ? mcnd_q : '0;
  mult_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (prod_q[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .carry(carry)
  );
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      mcnd_q <= '0;
      prod_q <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
    end else if (start) begin
      mcnd_q <= Mcnd;
      prod_q <= {{WIDTH{1'b0}}, Mplr};
      cnt    <= '0;
      rdy_q  <= 1'b0;
    end else if (step) begin
      prod_q <= {carry, sum, prod_q[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      rdy_q  <= last;
    end
  assign Prod = prod_q;
  assign Rdy  = rdy_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vectors for the shift-add multiplier, hand-computed products
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Run = 1'b0;
  logic [31:0] Mcnd = '0;
  logic [31:0] Mplr = '0;
  logic [63:0] Prod;
  logic        Rdy;
  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk (clk),
    .Rst (Rst),
    .Run (Run),
    .Mcnd(Mcnd),
    .Mplr(Mplr),
    .Prod(Prod),
    .Rdy (Rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Start at E0, expect Rdy low after E31 and high with the product after E32
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    @(negedge clk);
    Mcnd = a;
    Mplr = b;
    Run  = 1'b1;
    @(negedge clk);
    Run  = 1'b0;
    Mcnd = 32'hDEAD_BEEF;
    Mplr = 32'hCAFE_F00D;
    check({tag, "_rdy_e0"}, {63'd0, Rdy}, 64'd0);
    repeat (31) @(negedge clk);
    check({tag, "_rdy_e31"}, {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    check({tag, "_rdy_e32"}, {63'd0, Rdy}, 64'd1);
    check({tag, "_prod"}, Prod, exp);
  endtask

  initial begin
    #1;
    check("rst_prod", Prod, 64'd0);
    check("rst_rdy", {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", {63'd0, Rdy}, 64'd0);

    run_op("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("done_hold_rdy", {63'd0, Rdy}, 64'd1);
    check("done_hold_prod", Prod, 64'h0000_0000_0000_000F);
    run_op("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("m80x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    run_op("mx0", 32'h1234_5678, 32'd0, 64'd0);
    run_op("m0xf", 32'd0, 32'hFFFF_FFFF, 64'd0);

    // Run re-asserted at BUSY cycle 10 with other operands must be ignored
    @(negedge clk);
    Mcnd = 32'd1000;
    Mplr = 32'd1000;
    Run  = 1'b1;
    @(negedge clk);
    Run = 1'b0;
    repeat (9) @(negedge clk);
    Mcnd = 32'd11;
    Mplr = 32'd13;
    Run  = 1'b1;
    @(negedge clk);
    Run = 1'b0;
    repeat (21) @(negedge clk);
    check("ign_rdy_e31", {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    check("ign_rdy_e32", {63'd0, Rdy}, 64'd1);
    check("ign_prod", Prod, 64'd1_000_000);

    // Asynchronous reset mid-operation
    @(negedge clk);
    Mcnd = 32'hFFFF_FFFF;
    Mplr = 32'hFFFF_FFFF;
    Run  = 1'b1;
    @(negedge clk);
    Run = 1'b0;
    repeat (15) @(negedge clk);
    #2 Rst = 1'b1;
    #1;
    check("arst_prod", Prod, 64'd0);
    check("arst_rdy", {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    Rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_idle_rdy", {63'd0, Rdy}, 64'd0);
    check("arst_idle_prod", Prod, 64'd0);
    run_op("m7x9", 32'd7, 32'd9, 64'd63);

    // Run held high: back-to-back results 33 edges apart
    @(negedge clk);
    Mcnd = 32'd6;
    Mplr = 32'd7;
    Run  = 1'b1;
    @(negedge clk);
    Mcnd = 32'h0001_0000;
    Mplr = 32'h0001_0000;
    repeat (31) @(negedge clk);
    check("b2b_a_rdy_e31", {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    check("b2b_a_rdy_e32", {63'd0, Rdy}, 64'd1);
    check("b2b_a_prod", Prod, 64'd42);
    @(negedge clk);
    check("b2b_rdy_e33", {63'd0, Rdy}, 64'd0);
    repeat (31) @(negedge clk);
    check("b2b_b_rdy_e64", {63'd0, Rdy}, 64'd0);
    @(negedge clk);
    Run = 1'b0;
    check("b2b_b_rdy_e65", {63'd0, Rdy}, 64'd1);
    check("b2b_b_prod", Prod, 64'h0000_0001_0000_0000);
    @(negedge clk);
    check("b2b_b_hold_rdy", {63'd0, Rdy}, 64'd1);
    check("b2b_b_hold_prod", Prod, 64'h0000_0001_0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
